// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: credit-limited in-order instruction fetch into a {pc,inst} queue feeding decode
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEP = (CW + 1)'(DEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic acc, rsp_ok, keep, pop;
  assign redir_pc = redirect_pc & ~32'h3;
  assign imem_req_valid = !rst && !redirect && ({1'b0, count_q} + {1'b0, outst_q} < DEP);
  assign imem_req_addr = fetch_pc_q;
  assign out_valid = count_q != '0;
  assign out_pc = out_valid ? pc_mem[rptr_q] : 32'h0;
  assign out_inst = out_valid ? inst_mem[rptr_q] : 32'h0000_0013;
  always_comb begin
    acc = imem_req_valid && imem_req_ready;
    rsp_ok = imem_rsp_valid && outst_q != '0;
    keep = rsp_ok && drop_q == '0 && !redirect;
    pop = out_valid && out_ready && !redirect;
    fetch_pc_d = redirect ? redir_pc : acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d = redirect ? redir_pc : keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
    outst_d = outst_q + CW'(acc) - CW'(rsp_ok);
    drop_d = redirect ? outst_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
    count_d = redirect ? '0 : count_q + CW'(keep) - CW'(pop);
    wptr_d = redirect ? '0 : wptr_q + AW'(keep);
    rptr_d = redirect ? '0 : rptr_q + AW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (keep) begin
      pc_mem[wptr_q] <= rsp_pc_q;
      inst_mem[wptr_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of fetch credit, streaming, backpressure and redirect flushing
module tb_if_prefetch_queue;
  logic clk = 1'b0;
  logic rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect, out_valid, out_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, out_pc, out_inst;
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int lat = 1;
  int nacc = 0;
  logic [31:0] addr_q[$];
  int due_q[$];
  logic [31:0] bp_exp [4];
  if_prefetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic acc, rv, vld;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    rv = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (rv && addr_q.size() != 0) begin
      void'(addr_q.pop_front());
      void'(due_q.pop_front());
    end
    if (acc) begin
      addr_q.push_back(a);
      due_q.push_back(cyc + lat - 1);
      nacc++;
    end
    vld = addr_q.size() != 0 && due_q[0] <= cyc;
    imem_rsp_valid = vld;
    imem_rsp_data = vld ? (32'hC000_0000 | addr_q[0]) : 32'h0;
    #1;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    addr_q.delete();
    due_q.delete();
    imem_rsp_valid = 1'b0;
    nacc = 0;
    rst = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    bp_exp = '{32'h8, 32'hC, 32'h10, 32'h14};
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 32'h13);
    chk("rst_req_valid", imem_req_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("stream_lat_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_inst", out_inst, 32'hC000_0000 | 32'(4 * i));
    end
    out_ready = 1'b0;
    do_reset(2);
    repeat (8) tick();
    chk("bp_accepts", nacc, 4);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_req_addr", imem_req_addr, 32'h10);
    chk("bp_head_valid", out_valid, 1);
    chk("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    #1;
    tick();
    chk("bp_drain_pc", out_pc, 32'h4);
    chk("bp_resume_valid", imem_req_valid, 1);
    chk("bp_resume_addr", imem_req_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_drain_pc", out_pc, bp_exp[i]);
    end
    lat = 3;
    do_reset(2);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("redir_no_req", imem_req_valid, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_empty", out_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("redir_stale_valid", out_valid, 0);
      chk("redir_stale_inst", out_inst, 32'h13);
    end
    tick();
    chk("redir_new_pc", out_pc, 32'h100);
    chk("redir_new_inst", out_inst, 32'hC000_0100);
    tick();
    chk("redir_next_pc", out_pc, 32'h104);
    lat = 1;
    imem_req_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req_valid", imem_req_valid, 1);
      chk("stall_req_addr", imem_req_addr, 32'h0);
      chk("stall_out_valid", out_valid, 0);
    end
    imem_req_ready = 1'b1;
    #1;
    tick();
    chk("stall_lat_valid", out_valid, 0);
    tick();
    chk("stall_first_pc", out_pc, 32'h0);
    tick();
    chk("stall_second_pc", out_pc, 32'h4);
    lat = 2;
    do_reset(2);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    chk("coinc_empty", out_valid, 0);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("coinc_stale_valid", out_valid, 0);
    end
    tick();
    chk("coinc_new_valid", out_valid, 1);
    chk("coinc_new_pc", out_pc, 32'h200);
    chk("coinc_new_inst", out_inst, 32'hC000_0200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
